// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_pkg
// Purpose  : Shared FSM state encoding and display status codes for the clock.
// Revision : 1.0  initial release
// ============================================================================
package clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_SET_HOUR   = 2'd1,
        ST_SET_MINUTE = 2'd2,
        ST_STOP       = 2'd3
    } clock_state_t;

    localparam logic [2:0] SHOW_TIME   = 3'd0;
    localparam logic [2:0] SHOW_MINUTE = 3'd2;
    localparam logic [2:0] SHOW_HOUR   = 3'd3;
    localparam logic [2:0] SHOW_STOP   = 3'd6;

    function automatic logic [2:0] status_of(input clock_state_t state);
        logic [2:0] code;
        case (state)
            ST_SET_HOUR:   code = SHOW_HOUR;
            ST_SET_MINUTE: code = SHOW_MINUTE;
            ST_STOP:       code = SHOW_STOP;
            default:       code = SHOW_TIME;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Two-flop synchronizer, stability-count debounce and registered
//            rising-edge press pulse for one raw push-button.
// Revision : 1.0  initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic level,
    output logic press
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= key;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            // Any return to agreement restarts the stability window.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/clock_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_key_ctrl
// Purpose  : Key conditioning, mode FSM, blink phase and adjust pulses for the
//            digital clock. Define KEY_AUTOREPEAT_EN for increment auto-repeat.
// Revision : 1.0  initial release
// ============================================================================
module clock_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int BLINK_CYCLES    = 16384,
    parameter int REPEAT_DELAY    = 32768,
    parameter int REPEAT_PERIOD   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [2:0] status,
    output logic       run_en,
    output logic       hour_inc,
    output logic       minute_inc,
    output logic       second_clr,
    output logic       blink
);

    import clock_pkg::*;

    localparam int c_blink_w = $clog2(BLINK_CYCLES + 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_CYCLES - 1);

    logic         w_mode_level;
    logic         w_mode_press;
    logic         w_inc_level;
    logic         w_inc_press;
    logic         w_inc_fire;
    logic         w_unused;

    clock_state_t r_state;
    clock_state_t w_state_next;
    logic         r_hour_inc;
    logic         r_minute_inc;
    logic         r_second_clr;
    logic         w_hour_inc_next;
    logic         w_minute_inc_next;
    logic         w_second_clr_next;
    logic         w_next_in_set;

    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_mode),
        .level (w_mode_level),
        .press (w_mode_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_inc),
        .level (w_inc_level),
        .press (w_inc_press)
    );

`ifdef KEY_AUTOREPEAT_EN
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_rep_w   = $clog2(c_rep_max + 1);
    localparam logic [c_rep_w-1:0] c_rep_delay_last  = c_rep_w'(REPEAT_DELAY - 1);
    localparam logic [c_rep_w-1:0] c_rep_period_last = c_rep_w'(REPEAT_PERIOD - 1);

    logic               r_rep_active;
    logic               r_rep_periodic;
    logic [c_rep_w-1:0] r_rep_cnt;
    logic               w_rep_hold;
    logic               w_rep_fire;

    assign w_rep_hold = w_inc_level && !w_mode_press &&
                        ((r_state == ST_SET_HOUR) || (r_state == ST_SET_MINUTE));
    assign w_rep_fire = r_rep_active && w_rep_hold &&
                        (r_rep_cnt == (r_rep_periodic ? c_rep_period_last : c_rep_delay_last));

    // Counts from the edge that issued the press pulse; first gap is the delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_active   <= 1'b0;
            r_rep_periodic <= 1'b0;
            r_rep_cnt      <= '0;
        end else if (!w_rep_hold) begin
            r_rep_active   <= 1'b0;
            r_rep_periodic <= 1'b0;
            r_rep_cnt      <= '0;
        end else if (w_inc_press) begin
            r_rep_active   <= 1'b1;
            r_rep_periodic <= 1'b0;
            r_rep_cnt      <= '0;
        end else if (w_rep_fire) begin
            r_rep_periodic <= 1'b1;
            r_rep_cnt      <= '0;
        end else if (r_rep_active) begin
            r_rep_cnt      <= r_rep_cnt + 1'b1;
        end
    end

    assign w_inc_fire = w_inc_press | w_rep_fire;
    assign w_unused   = w_mode_level;
`else
    assign w_inc_fire = w_inc_press;
    assign w_unused   = ^{w_mode_level, w_inc_level, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_hour_inc   <= 1'b0;
            r_minute_inc <= 1'b0;
            r_second_clr <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_hour_inc   <= w_hour_inc_next;
            r_minute_inc <= w_minute_inc_next;
            r_second_clr <= w_second_clr_next;
        end
    end

    // A mode press takes priority, so a coincident increment is dropped.
    always_comb begin
        w_state_next      = r_state;
        w_hour_inc_next   = 1'b0;
        w_minute_inc_next = 1'b0;
        w_second_clr_next = 1'b0;
        if (w_mode_press) begin
            case (r_state)
                ST_RUN:        w_state_next = ST_SET_HOUR;
                ST_SET_HOUR:   w_state_next = ST_SET_MINUTE;
                ST_SET_MINUTE: w_state_next = ST_STOP;
                default: begin
                    w_state_next      = ST_RUN;
                    w_second_clr_next = 1'b1;
                end
            endcase
        end else if (w_inc_fire) begin
            w_hour_inc_next   = (r_state == ST_SET_HOUR);
            w_minute_inc_next = (r_state == ST_SET_MINUTE);
        end
    end

    assign w_next_in_set = (w_state_next == ST_SET_HOUR) || (w_state_next == ST_SET_MINUTE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (!w_next_in_set || (w_state_next != r_state)) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign status     = status_of(r_state);
    assign run_en     = (r_state == ST_RUN);
    assign hour_inc   = r_hour_inc;
    assign minute_inc = r_minute_inc;
    assign second_clr = r_second_clr;
    assign blink      = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_clock_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_key_ctrl
// Purpose  : Directed scoreboard bench for clock_key_ctrl (DEBOUNCE=4, BLINK=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_clock_key_ctrl;

    typedef struct {
        int kind;   // 0 status change, 1 hour_inc, 2 minute_inc, 3 second_clr
        int val;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_mode;
    logic       key_inc;
    logic [2:0] status;
    logic       run_en;
    logic       hour_inc;
    logic       minute_inc;
    logic       second_clr;
    logic       blink;

    int         cyc = 0;
    int         t_drive = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic       mon_en = 1'b0;
    logic [2:0] prev_status = 3'd0;
    exp_t       exp_q[$];

    clock_key_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .BLINK_CYCLES    (8),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_mode   (key_mode),
        .key_inc    (key_inc),
        .status     (status),
        .run_en     (run_en),
        .hour_inc   (hour_inc),
        .minute_inc (minute_inc),
        .second_clr (second_clr),
        .blink      (blink)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_event(input int kind, input int val);
        exp_t e;
        check("event_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_value", val, e.val);
            check("event_cycle", cyc, e.cyc);
        end
    endtask

    // Scoreboard side: every observed output event must match the queue head.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (status !== prev_status) check_event(0, int'(status));
            if (hour_inc)   check_event(1, 1);
            if (minute_inc) check_event(2, 1);
            if (second_clr) check_event(3, 1);
        end
        prev_status = status;
    end

    task automatic drive_start(input logic m, input logic i);
        @(negedge clk);
        t_drive  = cyc;
        key_mode = m;
        key_inc  = i;
    endtask

    task automatic release_after(input int n);
        repeat (n) @(negedge clk);
        key_mode = 1'b0;
        key_inc  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_ev(input int kind, input int val, input int dc);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = t_drive + dc;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish before 200000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        idle(3);
        check("reset_status", status, 0);
        check("reset_run_en", run_en, 1);
        check("reset_blink", blink, 1);
        check("reset_pulses", {hour_inc, minute_inc, second_clr}, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(3);

        // RUN -> SET_HOUR, blink phase from entry
        drive_start(1'b1, 1'b0);
        expect_ev(0, 3, 8);
        wait_until(t_drive + 8);
        check("set_hour_run_en", run_en, 0);
        for (int i = 0; i < 16; i++) begin
            check("set_hour_blink", blink, (i < 8) ? 1 : 0);
            @(negedge clk);
        end
        release_after(0);
        idle(10);

        // SET_HOUR -> SET_MINUTE
        drive_start(1'b1, 1'b0);
        expect_ev(0, 2, 8);
        release_after(10);
        idle(10);
        check("set_minute_run_en", run_en, 0);

        // increment in SET_MINUTE
        drive_start(1'b0, 1'b1);
        expect_ev(2, 1, 8);
        release_after(10);
        idle(10);

        // SET_MINUTE -> STOP, blink held high
        drive_start(1'b1, 1'b0);
        expect_ev(0, 6, 8);
        wait_until(t_drive + 8);
        for (int i = 0; i < 12; i++) begin
            check("stop_blink", blink, 1);
            @(negedge clk);
        end
        check("stop_run_en", run_en, 0);
        release_after(0);
        idle(10);

        // increment ignored in STOP
        drive_start(1'b0, 1'b1);
        release_after(10);
        idle(10);

        // STOP -> RUN with seconds clear
        drive_start(1'b1, 1'b0);
        expect_ev(0, 0, 8);
        expect_ev(3, 1, 8);
        release_after(10);
        idle(10);
        check("run_run_en", run_en, 1);

        // increment ignored in RUN
        drive_start(1'b0, 1'b1);
        release_after(10);
        idle(10);

        // back to SET_HOUR for debounce checks
        drive_start(1'b1, 1'b0);
        expect_ev(0, 3, 8);
        release_after(10);
        idle(10);

        // bounce 1-0-1-0 then stable high: one hour_inc
        drive_start(1'b0, 1'b1);
        @(negedge clk) key_inc = 1'b0;
        @(negedge clk) key_inc = 1'b1;
        @(negedge clk) key_inc = 1'b0;
        drive_start(1'b0, 1'b1);
        expect_ev(1, 1, 8);
        release_after(10);
        idle(10);

        // 3-cycle glitch filtered
        drive_start(1'b0, 1'b1);
        release_after(3);
        idle(12);

        // simultaneous mode + increment: mode wins
        drive_start(1'b1, 1'b1);
        expect_ev(0, 2, 8);
        release_after(10);
        idle(10);

        // asynchronous reset in SET_MINUTE
        mon_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_status", status, 0);
        check("midreset_run_en", run_en, 1);
        check("midreset_blink", blink, 1);
        check("midreset_pulses", {hour_inc, minute_inc, second_clr}, 0);
        key_mode = 1'b1;
        idle(3);

        // mode held through reset release counts as one press
        @(negedge clk);
        t_drive = cyc;
        rst_n   = 1'b1;
        mon_en  = 1'b1;
        expect_ev(0, 3, 8);
        release_after(10);
        idle(10);

        // held increment in SET_HOUR
        drive_start(1'b0, 1'b1);
        expect_ev(1, 1, 8);
`ifdef KEY_AUTOREPEAT_EN
        expect_ev(1, 1, 28);
        expect_ev(1, 1, 33);
        expect_ev(1, 1, 38);
`endif
        wait_until(t_drive + 36);
        key_inc = 1'b0;
        idle(20);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
